// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - shared types, constants and helpers for the stochastic node
// Purpose: log2 helper, FSM state encoding and MUX-select mode constants.
// Ports: none (package).
package stoch_pkg;

    // Constant-evaluable ceil(log2(value)); only used for parameter elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SCALE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int SEL_RR  = 0;
    localparam int SEL_RND = 1;

endpackage

// File: rtl/stoch_node_n_if.sv
// rtl/stoch_node_n_if.sv - job/bitstream/result bundle of the stochastic node
// Purpose: groups the start/busy, operand, per-cycle random and result
//          valid/ready signals of stoch_node_n.
// Modports:
//   master - job source and result consumer (drives start, operands, randoms, out_ready)
//   slave  - the node (drives busy, out_valid, x_out)
// rand_val carries the per-cycle LFSR value ("rand" is a reserved word).
interface stoch_node_n_if
    import stoch_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int LEN_W = 16
);
    localparam int SEL_W = clog2(N_IN);

    logic                    start;
    logic [LEN_W-1:0]        win_len;
    logic [N_IN*WIDTH-1:0]   x_bin;
    logic [N_IN-1:0]         w_bits;
    logic [WIDTH-1:0]        rand_val;
    logic [SEL_W-1:0]        sel_rnd;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        x_out;

    modport master (
        output start, win_len, x_bin, w_bits, rand_val, sel_rnd, out_ready,
        input  busy, out_valid, x_out
    );

    modport slave (
        input  start, win_len, x_bin, w_bits, rand_val, sel_rnd, out_ready,
        output busy, out_valid, x_out
    );

endinterface

// File: rtl/stoch_b2p_mult.sv
// rtl/stoch_b2p_mult.sv - one channel of binary-to-pulse conversion and stochastic multiply
// Purpose: s = (x > rand) unsigned, p = XNOR(w, s) (bipolar stochastic product bit).
// Ports:
//   i_x    in  WIDTH  latched binary operand
//   i_rand in  WIDTH  per-cycle LFSR value
//   i_w    in  1      per-cycle weight bit
//   o_p    out 1      product bit
module stoch_b2p_mult #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_rand,
    input  logic             i_w,
    output logic             o_p
);
    logic w_s;

    assign w_s = (i_x > i_rand);
    assign o_p = ~(i_w ^ w_s);

endmodule

// File: rtl/stoch_node_n.sv
// rtl/stoch_node_n.sv - N-input stochastic reservoir neuron with windowed counting and clip
// Purpose: over win_len cycles, MUX-selects one of N_IN stochastic product bits per
//          cycle, counts ones, rescales by N_IN and clips to ACT_MAX.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   stoch_node_n_if.slave (start/win_len/x_bin/w_bits/rand_val/sel_rnd in,
//         busy/out_valid/x_out out, out_ready in); interface parameters must match.
module stoch_node_n
    import stoch_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               N_IN     = 4,
    parameter int               LEN_W    = 16,
    parameter int               SEL_MODE = SEL_RR,
    parameter logic [WIDTH-1:0] ACT_MAX  = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    stoch_node_n_if.slave bus
);
    localparam int SEL_W    = clog2(N_IN);
    localparam int SCALED_W = LEN_W + SEL_W;
    localparam logic [SCALED_W-1:0] ACT_MAX_EXT = SCALED_W'(ACT_MAX);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_x_out;
    logic [N_IN*WIDTH-1:0] r_x_lat;
    logic [LEN_W-1:0]      r_win_lat;
    logic [LEN_W-1:0]      r_cyc_cnt;
    logic [LEN_W-1:0]      r_ones_cnt;

    logic [N_IN-1:0]       w_p;
    logic [SEL_W-1:0]      w_sel;
    logic                  w_p_sel;
    logic                  w_last;
    logic [SCALED_W-1:0]   w_scaled;
    logic [WIDTH-1:0]      w_x_clip;

    for (genvar j = 0; j < N_IN; j++) begin : g_mult
        stoch_b2p_mult #(.WIDTH(WIDTH)) u_mult (
            .i_x    (r_x_lat[j*WIDTH +: WIDTH]),
            .i_rand (bus.rand_val),
            .i_w    (bus.w_bits[j]),
            .o_p    (w_p[j])
        );
    end

    // Round-robin uses the low bits of the cycle counter, giving each channel
    // an equal share of the window when win_len is a multiple of N_IN.
    assign w_sel   = (SEL_MODE == SEL_RR) ? r_cyc_cnt[SEL_W-1:0] : bus.sel_rnd;
    assign w_p_sel = w_p[w_sel];
    assign w_last  = (r_cyc_cnt == r_win_lat - LEN_W'(1));

    // The MUX samples one of N_IN terms per cycle, so the count is scaled back up.
    assign w_scaled = {r_ones_cnt, {SEL_W{1'b0}}};
    assign w_x_clip = (w_scaled > ACT_MAX_EXT) ? ACT_MAX : w_scaled[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
            r_x_lat     <= '0;
            r_win_lat   <= '0;
            r_cyc_cnt   <= '0;
            r_ones_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_x_lat    <= bus.x_bin;
                        r_win_lat  <= bus.win_len;
                        r_cyc_cnt  <= '0;
                        r_ones_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= (bus.win_len == '0) ? ST_SCALE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_p_sel) begin
                        r_ones_cnt <= r_ones_cnt + LEN_W'(1);
                    end
                    r_cyc_cnt <= r_cyc_cnt + LEN_W'(1);
                    if (w_last) begin
                        r_state <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    r_x_out     <= w_x_clip;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.x_out     = r_x_out;

endmodule

// File: doc/stoch_node_n.md
Name: stoch_node_n

Overview:
- Parametrised successor to the two-input stochastic node.
- Generalises to N_IN scaled-add terms, a runtime-programmable bitstream window and two MUX-select modes.
- Adds an explicit start/busy/valid-ready handshake and a saturating output stage.
- Sits in the reservoir layer. Consumes an external LFSR value and weight bitstreams, and emits one binary neuron state per evaluation window.

Parameters:
- WIDTH, 16: binary data width of inputs, rand and output.
- N_IN, 4: number of product terms. Power of two, minimum 2.
- LEN_W, 16: width of the window-length and ones counter.
- SEL_MODE, 0: MUX select source. 0 = round-robin counter; 1 = external sel_rnd.
- ACT_MAX, 16'hFFFF: saturation ceiling of the activation clip.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin evaluation. Sampled only in IDLE.
- win_len  in  LEN_W  bitstream length in cycles. Latched at start.
- x_bin  in  N_IN*WIDTH  binary operands, channel j at [j*WIDTH +: WIDTH]. Latched at start.
- w_bits  in  N_IN  per-cycle weight stochastic bits.
- rand  in  WIDTH  per-cycle LFSR value for B2P comparison.
- sel_rnd  in  SEL_W = log2(N_IN)  per-cycle random MUX select. Used only when SEL_MODE=1.
- busy  out  1  high whenever state is not IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- x_out  out  WIDTH  neuron output.

Behaviour:
- Reset: asynchronous on rst_n low. Reset values: state=IDLE, busy=0, out_valid=0, x_out=0, all counters 0. Reset asserted mid-RUN or mid-HOLD aborts with no output.
- FSM states: IDLE, RUN, SCALE, HOLD.
  - IDLE: start=1 latches x_bin and win_len, clears ones_cnt and cyc_cnt. Go to RUN, or to SCALE if win_len==0.
  - RUN, per cycle:
    - s_j = (x_lat[j] > rand), unsigned.
    - p_j = ~(w_bits[j] ^ s_j).
    - sel = cyc_cnt[SEL_W-1:0] when SEL_MODE=0, else sel_rnd.
    - If p_sel==1, ones_cnt increments.
    - cyc_cnt increments. When cyc_cnt reaches win_len-1, go to SCALE.
    - Exactly win_len samples are counted.
  - SCALE: compute scaled = ones_cnt << SEL_W, width LEN_W+SEL_W, unsigned. This undoes the 1/N_IN MUX scaling. Register x_out = (scaled > ACT_MAX) ? ACT_MAX : scaled[WIDTH-1:0]. Set out_valid=1 and go to HOLD.
  - HOLD: x_out and out_valid stay stable until out_ready=1. Then out_valid drops next cycle and state returns to IDLE. start is ignored.
- Latency: start seen in cycle 0 → out_valid high from cycle win_len+2. For win_len==0, out_valid is high from cycle 2.
- Overflow: ones_cnt ≤ win_len, so it never overflows.
- Back-to-back operation: a new start is accepted in the first IDLE cycle after the handshake. There is no overlap of jobs.
- Input changes: changes on x_bin or win_len during a job have no effect.

Decomposition:
- Package stoch_pkg holds:
  - clog2 function;
  - state encoding constants ST_IDLE, ST_RUN, ST_SCALE, ST_HOLD;
  - SEL_RR / SEL_RND mode constants.
- One sub-module, stoch_b2p_mult: one channel's comparator plus XNOR. It is instantiated N_IN times with a generate loop.
- Counter, select MUX, FSM and the scale/clip stage remain in stoch_node_n.

Test Plan:
- All-ones product: N_IN=2, SEL_MODE=0, x_bin all 16'hFFFF, rand=16'h1234, w_bits=2'b11, win_len=100 → x_out=200, out_valid at cycle 102.
- All-zeros product: same as above but w_bits=2'b00 → x_out=0.
- Round-robin weighting:
  - ch0: x=16'hFFFF, w=1, giving p0=1.
  - ch1: x=0, w=1, giving p1=0.
  - win_len=100 → ones_cnt=50, x_out=100.
- Saturation: ACT_MAX=150 with the all-ones setup → x_out=150.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse start in that window → x_out and out_valid unchanged, start ignored, busy=1. Raise out_ready → out_valid=0 next cycle, then a fresh start is accepted.
- Reset and boundary:
  - Assert rst_n=0 at RUN cycle 40 → busy=0, out_valid=0, x_out=0 immediately; a subsequent win_len=100 job gives the correct result.
  - win_len=0 → x_out=0 at cycle 2.
